// File: rtl/voice_mixer.sv
// voice_mixer: multi-channel voice mixer, one multiply-accumulate per channel per cycle, saturated DAC output.
// Optional per-channel gain envelope (soft hush) enabled by defining VOICE_MIXER_SOFT_HUSH_EN.
module voice_mixer #(
  parameter int NUM_CH    = 4,
  parameter int SAMPLE_W  = 8,
  parameter int GAIN_W    = 4,
  parameter int OUT_W     = 8,
  parameter int OUT_SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sample_tick,
  input  logic [NUM_CH*SAMPLE_W-1:0]   ch_sample,
  input  logic [NUM_CH*GAIN_W-1:0]     ch_gain,
  input  logic [NUM_CH-1:0]            ch_hush,
  output logic [OUT_W-1:0]             mix_out,
  output logic                         mix_valid,
  output logic                         busy,
  output logic                         clip,
  output logic                         overrun
);
  localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_CH + 1);
  localparam int PROD_W = SAMPLE_W + GAIN_W;
  localparam int RES_W  = ACC_W + OUT_SHIFT;
  localparam int IDX_W  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;
  logic [1:0]                   state;
  logic [NUM_CH*SAMPLE_W-1:0]   snap_sample;
  logic [NUM_CH*GAIN_W-1:0]     snap_gain;
  logic [NUM_CH*GAIN_W-1:0]     eff_gain;
  logic [ACC_W-1:0]             acc;
  logic [IDX_W-1:0]             idx;
  logic [SAMPLE_W-1:0]          cur_s;
  logic [GAIN_W-1:0]            cur_g;
  logic [PROD_W-1:0]            prod;
  logic [RES_W-1:0]             res;
  logic                         sat;
  logic                         accept;
  assign busy   = state != IDLE;
  assign accept = sample_tick && state == IDLE;
  always_comb begin
    cur_s = '0;
    cur_g = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (idx == IDX_W'(i)) begin
        cur_s = snap_sample[i*SAMPLE_W +: SAMPLE_W];
        cur_g = snap_gain[i*GAIN_W +: GAIN_W];
      end
  end
  assign prod = PROD_W'(cur_s) * PROD_W'(cur_g);
  assign res  = RES_W'(acc >> GAIN_W) << OUT_SHIFT;
  assign sat  = |res[RES_W-1:OUT_W];
`ifdef VOICE_MIXER_SOFT_HUSH_EN
  logic [NUM_CH*GAIN_W-1:0] env;
  function automatic logic [GAIN_W-1:0] env_step(input logic [GAIN_W-1:0] e, input logic [GAIN_W-1:0] t,
                                                 input logic h);
    return h ? (e == '0 ? e : e - 1'b1) : (e < t ? e + 1'b1 : t);
  endfunction
  // The envelope steps before use, so the frame mixes with the updated gain.
  always_comb begin
    eff_gain = '0;
    for (int i = 0; i < NUM_CH; i++)
      eff_gain[i*GAIN_W +: GAIN_W] = env_step(env[i*GAIN_W +: GAIN_W], ch_gain[i*GAIN_W +: GAIN_W], ch_hush[i]);
  end
  always_ff @(posedge clk)
    if (!rst_n) env <= '0;
    else if (accept) env <= eff_gain;
`else
  always_comb begin
    eff_gain = '0;
    for (int i = 0; i < NUM_CH; i++)
      eff_gain[i*GAIN_W +: GAIN_W] = ch_hush[i] ? '0 : ch_gain[i*GAIN_W +: GAIN_W];
  end
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      snap_sample <= '0;
      snap_gain   <= '0;
      acc         <= '0;
      idx         <= '0;
      mix_out     <= '0;
      mix_valid   <= 1'b0;
      clip        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (sample_tick && busy) overrun <= 1'b1;
      if (accept) begin
        snap_sample <= ch_sample;
        snap_gain   <= eff_gain;
        acc         <= '0;
        idx         <= '0;
        state       <= ACCUM;
      end else if (state == ACCUM) begin
        acc   <= acc + ACC_W'(prod);
        idx   <= idx + 1'b1;
        state <= idx == IDX_W'(NUM_CH - 1) ? SCALE : ACCUM;
      end else if (state == SCALE) begin
        mix_out   <= sat ? '1 : res[OUT_W-1:0];
        clip      <= sat;
        mix_valid <= 1'b1;
        state     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: scoreboard bench for voice_mixer; expected frames are queued at tick time and
// checked by an independent monitor whenever mix_valid is seen.
module tb_voice_mixer;
  localparam int NUM_CH = 4, SAMPLE_W = 8, GAIN_W = 4, OUT_W = 8, OUT_SHIFT = 2;
  localparam int MAXV = (1 << OUT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0, sample_tick = 1'b0;
  logic [NUM_CH*SAMPLE_W-1:0] ch_sample = '0;
  logic [NUM_CH*GAIN_W-1:0]   ch_gain = '0;
  logic [NUM_CH-1:0]          ch_hush = '0;
  logic [OUT_W-1:0]           mix_out;
  logic                       mix_valid, busy, clip, overrun;
  voice_mixer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .ch_sample(ch_sample), .ch_gain(ch_gain),
    .ch_hush(ch_hush), .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .clip(clip), .overrun(overrun));
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {int due; int out; bit clp;} exp_t;
  exp_t sbq[$];
  int checks = 0, failures = 0;
  int env[NUM_CH];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk)
    if (mix_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_mix_valid: got mix_out=%0d with nothing expected (cycle %0d)", mix_out, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("mix_valid_cycle", cyc, e.due);
        chk("mix_out", int'(mix_out), e.out);
        chk("clip", int'(clip), int'(e.clp));
      end
    end
  task automatic model(output int o, output bit c);
    int sum, s, t, g, r;
    sum = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      s = int'(ch_sample[i*SAMPLE_W +: SAMPLE_W]);
      t = int'(ch_gain[i*GAIN_W +: GAIN_W]);
`ifdef VOICE_MIXER_SOFT_HUSH_EN
      if (ch_hush[i]) env[i] = env[i] > 0 ? env[i] - 1 : 0;
      else if (env[i] < t) env[i] = env[i] + 1;
      else env[i] = t;
      g = env[i];
`else
      g = ch_hush[i] ? 0 : t;
`endif
      sum += s * g;
    end
    r = (sum / (1 << GAIN_W)) * (1 << OUT_SHIFT);
    c = r > MAXV;
    o = c ? MAXV : r;
  endtask
  task automatic issue(input bit use_c, input int c_out, input bit c_clip);
    exp_t e;
    int mo;
    bit mc;
    @(posedge clk); #1;
    sample_tick = 1'b1;
    model(mo, mc);
    e.due = cyc + NUM_CH + 2;
    e.out = use_c ? c_out : mo;
    e.clp = use_c ? c_clip : mc;
    sbq.push_back(e);
    @(posedge clk); #1;
    sample_tick = 1'b0;
  endtask
  task automatic wait_frame();
    repeat (NUM_CH + 3) @(posedge clk);
  endtask
  task automatic randomize_inputs();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sample[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'($urandom);
      ch_gain[i*GAIN_W +: GAIN_W] = GAIN_W'($urandom);
    end
    ch_hush = NUM_CH'($urandom);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < NUM_CH; i++) env[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mix_out", int'(mix_out), 0);
    chk("reset_mix_valid", int'(mix_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_clip", int'(clip), 0);
    chk("reset_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ch_gain = 16'hFFFF;
    ch_hush = 4'b0000;
`ifdef VOICE_MIXER_SOFT_HUSH_EN
    ch_sample = {8'd0, 8'd0, 8'd0, 8'd16};
    for (int k = 1; k <= 15; k++) begin
      issue(1'b1, 4 * k, 1'b0);
      wait_frame();
    end
    ch_hush = 4'b0001;
    for (int k = 14; k >= 0; k--) begin
      issue(1'b1, 4 * k, 1'b0);
      wait_frame();
    end
    issue(1'b1, 0, 1'b0);
    wait_frame();
`else
    ch_sample = {8'd16, 8'd12, 8'd8, 8'd4};
    issue(1'b1, 148, 1'b0);
    @(negedge clk);
    chk("busy_in_frame", int'(busy), 1);
    randomize_inputs();
    wait_frame();
    chk("mix_out_held", int'(mix_out), 148);
    ch_sample = '1;
    ch_gain = 16'hFFFF;
    ch_hush = 4'b0000;
    issue(1'b1, 255, 1'b1);
    wait_frame();
    chk("clip_held", int'(clip), 1);
    ch_sample = {8'd16, 8'd12, 8'd8, 8'd4};
    ch_hush = 4'b0001;
    issue(1'b1, 132, 1'b0);
    wait_frame();
    chk("clip_cleared", int'(clip), 0);
`endif
    for (int n = 0; n < 24; n++) begin
      randomize_inputs();
      issue(1'b0, 0, 1'b0);
      randomize_inputs();
      wait_frame();
    end
    chk("overrun_before", int'(overrun), 0);
    randomize_inputs();
    issue(1'b0, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    sample_tick = 1'b1;
    @(negedge clk);
    chk("overrun_at_T3", int'(overrun), 0);
    @(posedge clk); #1;
    sample_tick = 1'b0;
    @(negedge clk);
    chk("overrun_at_T4", int'(overrun), 1);
    wait_frame();
    chk("overrun_sticky", int'(overrun), 1);
    randomize_inputs();
    issue(1'b0, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sbq.delete();
    for (int i = 0; i < NUM_CH; i++) env[i] = 0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_mix_out", int'(mix_out), 0);
    chk("abort_overrun", int'(overrun), 0);
    wait_frame();
    randomize_inputs();
    issue(1'b0, 0, 1'b0);
    wait_frame();
    repeat (4) @(posedge clk);
    chk("pending_frames", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of voice channels mixed, 1..16.
REQ-002 The block SHALL have parameter SAMPLE_W, default 8: width of each unsigned channel sample.
REQ-003 The block SHALL have parameter GAIN_W, default 4: width of each unsigned per-channel gain; gain (2^GAIN_W)-1 ≈ unity.
REQ-004 The block SHALL have parameter OUT_W, default 8: width of the unsigned mixed output fed to the dac.
REQ-005 The block SHALL have parameter OUT_SHIFT, default 2: left shift applied to the mixed sum before saturation.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-008 The block SHALL have port sample_tick, input, 1 bit: one-cycle pulse requesting one mix frame.
REQ-009 The block SHALL have port ch_sample, input, NUM_CH*SAMPLE_W bits: channel i at bits [i*SAMPLE_W +: SAMPLE_W].
REQ-010 The block SHALL have port ch_gain, input, NUM_CH*GAIN_W bits: target gain of channel i at bits [i*GAIN_W +: GAIN_W].
REQ-011 The block SHALL have port ch_hush, input, NUM_CH bits: bit i=1 mutes channel i.
REQ-012 The block SHALL have port mix_out, output, OUT_W bits: registered mixed sample, held between frames.
REQ-013 The block SHALL have port mix_valid, output, 1 bit: one-cycle pulse when mix_out updates.
REQ-014 The block SHALL have port busy, output, 1 bit: high while a frame is in progress.
REQ-015 The block SHALL have ports clip and overrun, outputs, 1 bit each: clip = last frame saturated; overrun = sticky, tick arrived while busy.

Function
REQ-016 The block SHALL implement FSM states IDLE, ACCUM and SCALE.
REQ-017 In IDLE, sample_tick=1 SHALL register ch_sample, ch_gain and ch_hush into snapshot registers, clear the accumulator, set channel index to 0 and enter ACCUM; busy=1 from the next cycle.
REQ-018 In ACCUM, each cycle SHALL add sample[idx]*eff_gain[idx] (full precision) to the accumulator, width SAMPLE_W+GAIN_W+ceil(log2(NUM_CH+1)), and increment idx; after idx=NUM_CH-1 the FSM SHALL enter SCALE.
REQ-019 In SCALE, the block SHALL compute (acc >> GAIN_W) << OUT_SHIFT, truncating; if the result exceeds 2^OUT_W-1, mix_out SHALL be 2^OUT_W-1 and clip=1; otherwise mix_out=result and clip=0; mix_valid pulses; FSM returns to IDLE.
REQ-020 Latency: tick sampled at cycle T SHALL produce mix_valid at cycle T+NUM_CH+2; a new tick SHALL be accepted in the cycle after mix_valid.
REQ-021 A sample_tick while busy=1, including the SCALE cycle, SHALL be ignored for mixing and SHALL set overrun=1; overrun clears only on reset.
REQ-022 Input changes during a frame SHALL NOT affect that frame; only snapshot values are used.
REQ-023 mix_out and clip SHALL hold their values until the next SCALE.

Reset
REQ-024 With rst_n=0 at a clock edge, the block SHALL force FSM to IDLE and clear mix_out, mix_valid, busy, clip, overrun, accumulator, index, snapshots and envelopes to 0.
REQ-025 Reset mid-frame SHALL abort the frame with no mix_valid pulse; mix_out SHALL read 0.

Configuration
REQ-026 With VOICE_MIXER_SOFT_HUSH_EN defined, each channel SHALL keep a GAIN_W-bit envelope updated once per accepted tick before use: if hushed, decrement by 1, floor 0; else if below target, increment by 1; else if above target, load target; eff_gain = envelope.
REQ-027 Without VOICE_MIXER_SOFT_HUSH_EN, no envelope registers SHALL exist and eff_gain SHALL be 0 if hushed, else ch_gain, snapshotted.

Verification (NUM_CH=4, SAMPLE_W=8, GAIN_W=4, OUT_W=8, OUT_SHIFT=2)
REQ-028 A bench SHALL cover: macro off, samples 4,8,12,16, gain 15 all, no hush, tick at T -> mix_out=148, clip=0, mix_valid only at T+6.
REQ-029 A bench SHALL cover: macro off, all samples 255, gain 15 -> mix_out=255, clip=1.
REQ-030 A bench SHALL cover: macro off, REQ-028 stimulus with ch_hush=4'b0001 -> mix_out=132.
REQ-031 A bench SHALL cover: macro on, after reset, ch0 sample 16, others 0, gain 15, no hush, successive ticks -> mix_out=4, 8, 12, ...; then hush ch0 -> sequence decreases by 4 per frame to 0.
REQ-032 A bench SHALL cover: tick at T and T+3 -> one mix_valid at T+6, overrun=1 from T+4, result equals single-frame value.
REQ-033 A bench SHALL cover: rst_n=0 at T+3 of a frame -> no mix_valid, busy=0 and mix_out=0 from T+4.
